// File: rtl/sd4_mac_pkg.sv
// Shared types and widths for the SD4 MAC datapath.
package sd4_mac_pkg;

  localparam int PSUM_W = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DRAIN = 2'd2
  } psum_buf_state_t;

endpackage

// File: rtl/psum_mem.sv
// DEPTH x W psum register file: synchronous clear, one registered read port with
// write forwarding, one write port, and a combinational tap used by the drain stage.
module psum_mem
  import sd4_mac_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int AW    = $clog2(DEPTH),
  parameter int W     = PSUM_W
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  input  logic          rd_en,
  input  logic [AW-1:0] rd_idx,
  output logic [W-1:0]  rd_data,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_idx,
  input  logic [W-1:0]  wr_data,
  input  logic [AW-1:0] tap_idx,
  output logic [W-1:0]  tap_data
);

  logic [W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (wr_en) begin
      mem[wr_idx] <= wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_data <= '0;
    end else if (rd_en) begin
      rd_data <= (wr_en && (wr_idx == rd_idx)) ? wr_data : mem[rd_idx];
    end
  end

  // Forwarding on the tap covers a write-back committed on the edge that enters drain.
  assign tap_data = (wr_en && (wr_idx == tap_idx)) ? wr_data : mem[tap_idx];

endmodule

// File: rtl/psum_buffer.sv
// Partial-sum buffer between the PE and the output stage: accumulate passes, then drain.
// Build option PSUM_RELU_EN: clamp entries with the sign bit set to zero on drain.
//
//   state | meaning
//   IDLE  | waiting for start; PE-side strobes ignored
//   ACCUM | PE reads/write-backs active; counting passes
//   DRAIN | streaming entries 0..DEPTH-1 out over valid/ready
module psum_buffer
  import sd4_mac_pkg::*;
#(
  parameter int DEPTH  = 16,
  parameter int AW     = $clog2(DEPTH),
  parameter int PSUM_W = sd4_mac_pkg::PSUM_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [3:0]        n_pass,
  input  logic              rd_en,
  input  logic [AW-1:0]     rd_idx,
  output logic [PSUM_W-1:0] psum,
  input  logic              wr_en,
  input  logic [AW-1:0]     wr_idx,
  input  logic [PSUM_W-1:0] psum_in,
  input  logic              pass_done,
  output logic              busy,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [PSUM_W-1:0] out_data,
  output logic [AW-1:0]     out_idx,
  output logic              out_last,
  output logic              done
);

  localparam logic [AW-1:0] LAST_IDX = AW'(DEPTH - 1);

  psum_buf_state_t   state;
  logic [3:0]        passes_left;
  logic              mem_clr, mem_rd, mem_wr;
  logic [AW-1:0]     next_idx, tap_idx;
  logic [PSUM_W-1:0] tap_data, drain_word;

  assign mem_clr  = (state == IDLE) && start;
  assign mem_rd   = (state == ACCUM) && rd_en;
  assign mem_wr   = (state == ACCUM) && wr_en;
  assign next_idx = out_idx + 1'b1;
  assign tap_idx  = (state == DRAIN) ? next_idx : '0;

`ifdef PSUM_RELU_EN
  assign drain_word = tap_data[PSUM_W-1] ? '0 : tap_data;
`else
  assign drain_word = tap_data;
`endif

  psum_mem #(.DEPTH(DEPTH), .AW(AW), .W(PSUM_W)) u_mem (
    .clk      (clk),
    .rst      (rst),
    .clr      (mem_clr),
    .rd_en    (mem_rd),
    .rd_idx   (rd_idx),
    .rd_data  (psum),
    .wr_en    (mem_wr),
    .wr_idx   (wr_idx),
    .wr_data  (psum_in),
    .tap_idx  (tap_idx),
    .tap_data (tap_data)
  );

  // Pass counter runs down from n_pass-1; terminal count is zero.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      passes_left <= '0;
      busy        <= 1'b0;
      out_valid   <= 1'b0;
      out_data    <= '0;
      out_idx     <= '0;
      out_last    <= 1'b0;
      done        <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            passes_left <= (n_pass == 4'd0) ? 4'd0 : n_pass - 4'd1;
            busy        <= 1'b1;
            state       <= ACCUM;
          end
        end
        ACCUM: begin
          if (pass_done) begin
            if (passes_left == 4'd0) begin
              state     <= DRAIN;
              out_valid <= 1'b1;
              out_idx   <= '0;
              out_data  <= drain_word;
              out_last  <= 1'b0;
            end else begin
              passes_left <= passes_left - 4'd1;
            end
          end
        end
        DRAIN: begin
          if (out_valid && out_ready) begin
            if (out_idx == LAST_IDX) begin
              state     <= IDLE;
              busy      <= 1'b0;
              out_valid <= 1'b0;
              out_data  <= '0;
              out_idx   <= '0;
              out_last  <= 1'b0;
              done      <= 1'b1;
            end else begin
              out_idx  <= next_idx;
              out_data <= drain_word;
              out_last <= (next_idx == LAST_IDX);
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_psum_buffer.sv
// Directed self-checking bench for psum_buffer: table-driven accumulate vectors plus
// hand-written drain, backpressure, ReLU and reset sequences.
module tb_psum_buffer;

  logic        clk = 1'b0;
  logic        rst, start, rd_en, wr_en, pass_done, out_ready;
  logic [3:0]  n_pass, rd_idx, wr_idx;
  logic [15:0] psum_in;
  logic [15:0] psum, out_data;
  logic [3:0]  out_idx;
  logic        busy, out_valid, out_last, done;

  int n_checks = 0;
  int n_err    = 0;
  logic [15:0] exp_mem [16];

  psum_buffer #(.DEPTH(16)) dut (
    .clk(clk), .rst(rst), .start(start), .n_pass(n_pass),
    .rd_en(rd_en), .rd_idx(rd_idx), .psum(psum),
    .wr_en(wr_en), .wr_idx(wr_idx), .psum_in(psum_in),
    .pass_done(pass_done), .busy(busy),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_idx(out_idx), .out_last(out_last), .done(done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rd_en;
    logic [3:0]  rd_idx;
    logic        wr_en;
    logic [3:0]  wr_idx;
    logic [15:0] wdata;
    logic        pass_done;
    logic [15:0] exp_psum;
  } vec_t;

  vec_t vecs [10];

  function automatic vec_t mk(logic r, logic [3:0] ri, logic w, logic [3:0] wi,
                              logic [15:0] wd, logic pd, logic [15:0] ep);
    vec_t v;
    v.rd_en = r; v.rd_idx = ri; v.wr_en = w; v.wr_idx = wi;
    v.wdata = wd; v.pass_done = pd; v.exp_psum = ep;
    return v;
  endfunction

  function automatic logic [15:0] relu_exp(logic [15:0] v);
`ifdef PSUM_RELU_EN
    return v[15] ? 16'h0000 : v;
`else
    return v;
`endif
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic idle_inputs();
    start = 0; rd_en = 0; wr_en = 0; pass_done = 0; out_ready = 0;
    rd_idx = 0; wr_idx = 0; psum_in = 0; n_pass = 0;
  endtask

  task automatic check_zero_outputs(string tag);
    chk({tag, " psum"}, 32'(psum), 0);
    chk({tag, " busy"}, 32'(busy), 0);
    chk({tag, " out_valid"}, 32'(out_valid), 0);
    chk({tag, " out_data"}, 32'(out_data), 0);
    chk({tag, " out_idx"}, 32'(out_idx), 0);
    chk({tag, " out_last"}, 32'(out_last), 0);
    chk({tag, " done"}, 32'(done), 0);
  endtask

  task automatic start_tile(logic [3:0] np);
    start = 1; n_pass = np;
    tick();
    start = 0; n_pass = 0;
    chk("busy after start", 32'(busy), 1);
  endtask

  // Called with the DUT already in DRAIN; out_ready held high.
  task automatic drain_all(string tag);
    out_ready = 1;
    for (int i = 0; i < 16; i++) begin
      chk({tag, " drain valid"}, 32'(out_valid), 1);
      chk({tag, " drain idx"}, 32'(out_idx), 32'(i));
      chk({tag, " drain data"}, 32'(out_data), 32'(relu_exp(exp_mem[i])));
      chk({tag, " drain last"}, 32'(out_last), 32'(i == 15));
      chk({tag, " drain busy"}, 32'(busy), 1);
      tick();
    end
    out_ready = 0;
    chk({tag, " done pulse"}, 32'(done), 1);
    chk({tag, " busy at done"}, 32'(busy), 0);
    chk({tag, " valid at done"}, 32'(out_valid), 0);
    tick();
    chk({tag, " done single"}, 32'(done), 0);
  endtask

  initial begin
    logic [3:0]  pat;
    logic [15:0] prev_data;
    logic [3:0]  prev_idx;
    logic        prev_stall;
    int          nxt, k;

    idle_inputs();
    rst = 1;
    tick(); tick();
    rst = 0;
    check_zero_outputs("reset");

    // Empty tile: n_pass=1, immediate pass_done, everything drains as zero.
    for (int i = 0; i < 16; i++) exp_mem[i] = 16'h0000;
    start_tile(4'd1);
    pass_done = 1; tick(); pass_done = 0;
    drain_all("empty");

    // IDLE ignores PE-side strobes.
    rd_en = 1; rd_idx = 2; wr_en = 1; wr_idx = 2; psum_in = 16'h5555; pass_done = 1;
    tick();
    idle_inputs();
    chk("idle psum", 32'(psum), 0);
    chk("idle busy", 32'(busy), 0);

    // Main two-pass tile, one vector per cycle.
    vecs[0] = mk(0, 0, 1, 3, 16'h000F, 0, 16'h0000);
    vecs[1] = mk(1, 3, 1, 7, 16'h8001, 0, 16'h000F);
    vecs[2] = mk(1, 5, 1, 5, 16'h1234, 0, 16'h1234);
    vecs[3] = mk(1, 7, 0, 0, 16'h0000, 0, 16'h8001);
    vecs[4] = mk(0, 0, 0, 0, 16'h0000, 0, 16'h8001);
    vecs[5] = mk(0, 0, 0, 0, 16'h0000, 1, 16'h8001);
    vecs[6] = mk(1, 3, 0, 0, 16'h0000, 0, 16'h000F);
    vecs[7] = mk(0, 0, 1, 3, 16'h00FF, 0, 16'h000F);
    vecs[8] = mk(1, 3, 0, 0, 16'h0000, 0, 16'h00FF);
    vecs[9] = mk(0, 0, 1, 0, 16'hB600, 1, 16'h00FF);

    start_tile(4'd2);
    for (int v = 0; v < 10; v++) begin
      rd_en = vecs[v].rd_en; rd_idx = vecs[v].rd_idx;
      wr_en = vecs[v].wr_en; wr_idx = vecs[v].wr_idx; psum_in = vecs[v].wdata;
      pass_done = vecs[v].pass_done;
      tick();
      idle_inputs();
      chk($sformatf("vec%0d psum", v), 32'(psum), 32'(vecs[v].exp_psum));
    end
    for (int i = 0; i < 16; i++) exp_mem[i] = 16'h0000;
    exp_mem[0] = 16'hB600; exp_mem[3] = 16'h00FF;
    exp_mem[5] = 16'h1234; exp_mem[7] = 16'h8001;
    drain_all("main");

    // Backpressure tile; n_pass=0 acts as one pass; a start while busy is ignored.
    start_tile(4'd0);
    for (int i = 0; i < 16; i++) begin
      wr_en = 1; wr_idx = 4'(i); psum_in = 16'h0A00 | 16'(i);
      if (i == 4) begin start = 1; n_pass = 4'd3; end
      tick();
      idle_inputs();
    end
    chk("busy after ignored start", 32'(busy), 1);
    pass_done = 1; tick(); pass_done = 0;
    chk("bp drain entered", 32'(out_valid), 1);
    pat = 4'b1001; nxt = 0; k = 0; prev_stall = 0; prev_idx = 0; prev_data = 0;
    while (done !== 1'b1 && k < 200) begin
      out_ready = pat[k % 4];
      if (out_valid) begin
        if (prev_stall) begin
          chk("bp stable idx", 32'(out_idx), 32'(prev_idx));
          chk("bp stable data", 32'(out_data), 32'(prev_data));
        end
        if (out_ready) begin
          chk("bp idx order", 32'(out_idx), 32'(nxt));
          chk("bp data", 32'(out_data), 32'(16'h0A00 | 16'(nxt)));
          chk("bp last", 32'(out_last), 32'(nxt == 15));
          nxt++;
        end
        prev_stall = !out_ready; prev_idx = out_idx; prev_data = out_data;
      end
      tick();
      k++;
    end
    out_ready = 0;
    chk("bp handshake count", 32'(nxt), 16);
    chk("bp done", 32'(done), 1);
    tick();

    // Reset mid-drain at idx 7, then a fresh tile reads zero everywhere.
    start_tile(4'd1);
    wr_en = 1; wr_idx = 9; psum_in = 16'h0ABC; tick(); idle_inputs();
    rd_en = 1; rd_idx = 9; tick(); idle_inputs();
    chk("pre-reset psum", 32'(psum), 32'h0ABC);
    pass_done = 1; tick(); pass_done = 0;
    out_ready = 1; k = 0;
    while (out_idx != 4'd7 && k < 20) begin tick(); k++; end
    out_ready = 0;
    chk("mid-drain idx", 32'(out_idx), 7);
    rst = 1; tick(); rst = 0;
    check_zero_outputs("mid-drain reset");
    for (int i = 0; i < 16; i++) exp_mem[i] = 16'h0000;
    start_tile(4'd1);
    rd_en = 1; rd_idx = 9; tick(); idle_inputs();
    chk("fresh psum idx9", 32'(psum), 0);
    pass_done = 1; tick(); pass_done = 0;
    drain_all("fresh");

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
